// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Holds the fetch PC, issues one
//                instruction-memory request at a time, and hands {pc, inst}
//                to decode. Redirects squash in-flight work and restart fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h8000_0000,
    parameter int unsigned INST_LENGTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    localparam logic [1:0] c_REQ  = 2'd0;  // presenting a request
    localparam logic [1:0] c_WAIT = 2'd1;  // request accepted, awaiting response
    localparam logic [1:0] c_DROP = 2'd2;  // awaiting response of a squashed request
    localparam logic [1:0] c_HOLD = 2'd3;  // instruction held for decode

    localparam logic [31:0] c_INST_INC = 32'(INST_LENGTH);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_inst;
    logic        w_req_fire;
    logic        w_capture;
    logic [31:0] w_redirect_target;

    // Redirect targets are word aligned; the low two bits are simply cleared.
    assign w_redirect_target = redirect_pc & ~32'h0000_0003;

    assign imem_req_valid = (r_state == c_REQ) & ~rst;
    assign imem_req_addr  = r_fetch_pc;
    assign if_valid       = (r_state == c_HOLD);
    assign if_pc          = r_if_pc;
    assign if_inst        = r_if_inst;

    assign w_req_fire = imem_req_valid & imem_req_ready;
    // A response is only kept when it belongs to a live (unsquashed) request.
    assign w_capture  = (r_state == c_WAIT) & imem_rsp_valid & ~redirect_valid;

    // Next-state decode; redirect takes priority over every other event.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_REQ: begin
                if (redirect_valid)
                    w_state_nxt = w_req_fire ? c_DROP : c_REQ;
                else if (w_req_fire)
                    w_state_nxt = c_WAIT;
            end
            c_WAIT: begin
                if (redirect_valid)
                    w_state_nxt = imem_rsp_valid ? c_REQ : c_DROP;
                else if (imem_rsp_valid)
                    w_state_nxt = c_HOLD;
            end
            c_DROP: begin
                if (imem_rsp_valid)
                    w_state_nxt = c_REQ;
            end
            c_HOLD: begin
                if (redirect_valid || if_ready)
                    w_state_nxt = c_REQ;
            end
            default: w_state_nxt = c_REQ;
        endcase
    end

    // State register and fetch PC update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_REQ;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            if (redirect_valid)
                r_fetch_pc <= w_redirect_target;
            else if (w_capture)
                r_fetch_pc <= r_fetch_pc + c_INST_INC;
        end
    end

    // Capture of the fetched instruction and its PC for decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_pc   <= 32'h0;
            r_if_inst <= 32'h0;
        end else if (w_capture) begin
            r_if_pc   <= r_fetch_pc;
            r_if_inst <= imem_rsp_data;
        end
    end

endmodule
`default_nettype wire
